// File: rtl/alu_arbiter_if.sv
// Bus bundle between alu_arbiter, its two requesters and the combinational ALU.
// The arbiter takes the slave view; requesters and the ALU side take the master view.
interface alu_arbiter_if #(
    parameter int n   = 32,
    parameter int OPW = 3
);
    logic           req0;
    logic [OPW-1:0] op0;
    logic [n-1:0]   a0;
    logic [n-1:0]   b0;
    logic           gnt0;
    logic           done0;

    logic           req1;
    logic [OPW-1:0] op1;
    logic [n-1:0]   a1;
    logic [n-1:0]   b1;
    logic           gnt1;
    logic           done1;

    logic [n-1:0]   result;
    logic [OPW-1:0] alu_op;
    logic [n-1:0]   alu_a;
    logic [n-1:0]   alu_b;
    logic [n-1:0]   alu_out;
    logic           busy;

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, alu_out,
        output gnt0, done0, gnt1, done1, result, alu_op, alu_a, alu_b, busy
    );

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, alu_out,
        input  gnt0, done0, gnt1, done1, result, alu_op, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// holds the winner's operands for SETTLE cycles, then returns the captured result.
module alu_arbiter #(
    parameter int          n      = 32,
    parameter int          OPW    = 3,
    parameter int unsigned SETTLE = 2
) (
    input  logic      clk,
    input  logic      rst,
    alu_arbiter_if.slave bus
);
    localparam int CW = 4;

    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
        $error("alu_arbiter: SETTLE must be in 1..15");
    end

    typedef enum logic {IDLE, EXEC} state_t;

    state_t         state, state_n;
    logic           last, last_n;
    logic           win, win_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           pick1;

    logic           gnt0_q, gnt0_n, gnt1_q, gnt1_n;
    logic           done0_q, done0_n, done1_q, done1_n;
    logic           busy_q, busy_n;
    logic [n-1:0]   result_q, result_n;
    logic [OPW-1:0] op_q, op_n;
    logic [n-1:0]   a_q, a_n, b_q, b_n;

    always_comb begin
        state_n  = state;
        last_n   = last;
        win_n    = win;
        cnt_n    = cnt;
        gnt0_n   = 1'b0;
        gnt1_n   = 1'b0;
        done0_n  = 1'b0;
        done1_n  = 1'b0;
        busy_n   = busy_q;
        result_n = result_q;
        op_n     = op_q;
        a_n      = a_q;
        b_n      = b_q;
        // requester 1 wins when it is alone, or on a tie when 0 went last
        pick1    = bus.req1 && (!bus.req0 || !last);

        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    if (pick1) begin
                        op_n   = bus.op1;
                        a_n    = bus.a1;
                        b_n    = bus.b1;
                        gnt1_n = 1'b1;
                    end else begin
                        op_n   = bus.op0;
                        a_n    = bus.a0;
                        b_n    = bus.b0;
                        gnt0_n = 1'b1;
                    end
                    last_n  = pick1;
                    win_n   = pick1;
                    cnt_n   = CW'(SETTLE);
                    busy_n  = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    result_n = bus.alu_out;
                    done0_n  = !win;
                    done1_n  = win;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            win      <= 1'b0;
            cnt      <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            win      <= win_n;
            cnt      <= cnt_n;
            gnt0_q   <= gnt0_n;
            gnt1_q   <= gnt1_n;
            done0_q  <= done0_n;
            done1_q  <= done1_n;
            busy_q   <= busy_n;
            result_q <= result_n;
            op_q     <= op_n;
            a_q      <= a_n;
            b_q      <= b_n;
        end
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.busy   = busy_q;
    assign bus.result = result_q;
    assign bus.alu_op = op_q;
    assign bus.alu_a  = a_q;
    assign bus.alu_b  = b_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one SETTLE=2 instance and one SETTLE=1 instance,
// each driving a small behavioural ALU.
module tb_alu_arbiter;
    localparam int N = 32;
    localparam int W = 3;
    localparam logic [2:0] OP_NOT = 3'd0, OP_AND = 3'd1, OP_OR = 3'd2,
                           OP_XOR = 3'd3, OP_ADD = 3'd4, OP_SUB = 3'd5;

    logic clk = 1'b0;
    logic rst;
    logic rst1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.n(N), .OPW(W)) bs2 ();
    alu_arbiter_if #(.n(N), .OPW(W)) bs1 ();

    alu_arbiter #(.n(N), .OPW(W), .SETTLE(2)) u_s2 (.clk(clk), .rst(rst),  .bus(bs2.slave));
    alu_arbiter #(.n(N), .OPW(W), .SETTLE(1)) u_s1 (.clk(clk), .rst(rst1), .bus(bs1.slave));

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            3'd6:    return a;
            default: return b;
        endcase
    endfunction

    assign bs2.alu_out = alu_fn(bs2.alu_op, bs2.alu_a, bs2.alu_b);
    assign bs1.alu_out = alu_fn(bs1.alu_op, bs1.alu_a, bs1.alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // {gnt0, gnt1, done0, done1}
    function automatic logic [3:0] pulses2();
        return {bs2.gnt0, bs2.gnt1, bs2.done0, bs2.done1};
    endfunction

    function automatic logic [3:0] pulses1();
        return {bs1.gnt0, bs1.gnt1, bs1.done0, bs1.done1};
    endfunction

    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [31:0] pr [4];
    logic [3:0]  expf;

    initial begin
        pa = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678, 32'h7FFF_FFFF};
        pb = '{32'h0000_0002, 32'h0000_0001, 32'h1111_1111, 32'h0000_0001};
        pr = '{32'h0000_0003, 32'h0000_0000, 32'h2345_6789, 32'h8000_0000};

        rst  = 1'b1;
        rst1 = 1'b1;
        bs2.req0 = 1'b0; bs2.op0 = '0; bs2.a0 = '0; bs2.b0 = '0;
        bs2.req1 = 1'b0; bs2.op1 = '0; bs2.a1 = '0; bs2.b1 = '0;
        bs1.req0 = 1'b0; bs1.op0 = '0; bs1.a0 = '0; bs1.b0 = '0;
        bs1.req1 = 1'b0; bs1.op1 = '0; bs1.a1 = '0; bs1.b1 = '0;

        // reset, then idle
        step(); step();
        chk("rst_pulses", {28'd0, pulses2()}, 32'd0);
        chk("rst_busy", {31'd0, bs2.busy}, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("idle_pulses_%0d", c), {27'd0, pulses2(), bs2.busy}, 32'd0);
        end
        chk("idle_result", bs2.result, 32'd0);
        chk("idle_alu_op", {29'd0, bs2.alu_op}, 32'd0);
        chk("idle_alu_a", bs2.alu_a, 32'd0);
        chk("idle_alu_b", bs2.alu_b, 32'd0);

        // single NOT on requester 0
        bs2.req0 = 1'b1; bs2.op0 = OP_NOT; bs2.a0 = 32'h0000_FFFF; bs2.b0 = 32'h0;
        step();
        chk("single_gnt", {28'd0, pulses2()}, 32'b1000);
        chk("single_busy1", {31'd0, bs2.busy}, 32'd1);
        chk("single_alu_a1", bs2.alu_a, 32'h0000_FFFF);
        bs2.req0 = 1'b0; bs2.a0 = 32'hDEAD_BEEF;
        step();
        chk("single_mid", {28'd0, pulses2()}, 32'b0000);
        chk("single_alu_a2", bs2.alu_a, 32'h0000_FFFF);
        chk("single_busy2", {31'd0, bs2.busy}, 32'd1);
        step();
        chk("single_done", {28'd0, pulses2()}, 32'b0010);
        chk("single_result", bs2.result, 32'hFFFF_0000);
        chk("single_busy3", {31'd0, bs2.busy}, 32'd0);
        step();
        chk("single_after", {28'd0, pulses2()}, 32'b0000);
        chk("single_held", bs2.result, 32'hFFFF_0000);

        // simultaneous requests right after reset: order 0,1,0,1
        rst = 1'b1;
        step();
        rst = 1'b0;
        bs2.req0 = 1'b1; bs2.op0 = OP_ADD; bs2.a0 = 32'h1;         bs2.b0 = 32'h2;
        bs2.req1 = 1'b1; bs2.op1 = OP_AND; bs2.a1 = 32'h0000_F0F0; bs2.b1 = 32'h0000_FF00;
        for (int c = 1; c <= 12; c++) begin
            int t, w, pos;
            step();
            t   = (c - 1) / 3;
            w   = t % 2;
            pos = (c - 1) % 3;
            if (pos == 0)      expf = (w != 0) ? 4'b0100 : 4'b1000;
            else if (pos == 2) expf = (w != 0) ? 4'b0001 : 4'b0010;
            else               expf = 4'b0000;
            chk($sformatf("rr_pulses_c%0d", c), {28'd0, pulses2()}, {28'd0, expf});
            if (pos == 2)
                chk($sformatf("rr_result_c%0d", c), bs2.result, (w != 0) ? 32'h0000_F000 : 32'h3);
            if (c == 12) begin
                bs2.req0 = 1'b0;
                bs2.req1 = 1'b0;
            end
        end

        // request from 1 arriving during 0's EXEC
        bs2.req0 = 1'b1; bs2.op0 = OP_OR; bs2.a0 = 32'h0F; bs2.b0 = 32'hF0;
        step();
        chk("exec_gnt0", {28'd0, pulses2()}, 32'b1000);
        bs2.req0 = 1'b0;
        bs2.req1 = 1'b1; bs2.op1 = OP_SUB; bs2.a1 = 32'd10; bs2.b1 = 32'd3;
        step();
        chk("exec_ignored", {28'd0, pulses2()}, 32'b0000);
        chk("exec_hold_op", {29'd0, bs2.alu_op}, {29'd0, OP_OR});
        chk("exec_hold_a", bs2.alu_a, 32'h0F);
        chk("exec_hold_b", bs2.alu_b, 32'hF0);
        step();
        chk("exec_done0", {28'd0, pulses2()}, 32'b0010);
        chk("exec_result0", bs2.result, 32'hFF);
        step();
        chk("exec_gnt1", {28'd0, pulses2()}, 32'b0100);
        chk("exec_alu_a1", bs2.alu_a, 32'd10);
        bs2.req1 = 1'b0;
        step();
        chk("exec_mid1", {28'd0, pulses2()}, 32'b0000);
        step();
        chk("exec_done1", {28'd0, pulses2()}, 32'b0001);
        chk("exec_result1", bs2.result, 32'd7);
        step();

        // reset in the first EXEC cycle aborts without a done
        bs2.req0 = 1'b1; bs2.op0 = OP_ADD; bs2.a0 = 32'd5; bs2.b0 = 32'd6;
        step();
        chk("abort_gnt0", {28'd0, pulses2()}, 32'b1000);
        bs2.req0 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_cleared", {27'd0, pulses2(), bs2.busy}, 32'd0);
        chk("abort_alu_a", bs2.alu_a, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("abort_no_done_%0d", c), {27'd0, pulses2(), bs2.busy}, 32'd0);
        end
        bs2.req0 = 1'b1;
        bs2.req1 = 1'b1; bs2.op1 = OP_XOR; bs2.a1 = 32'hFFFF_FFFF; bs2.b1 = 32'h0;
        step();
        chk("abort_tie_to_0", {28'd0, pulses2()}, 32'b1000);
        bs2.req0 = 1'b0;
        bs2.req1 = 1'b0;
        step();
        step();
        chk("abort_redo_done", {28'd0, pulses2()}, 32'b0010);
        chk("abort_redo_result", bs2.result, 32'd11);

        // SETTLE=1 instance: back-to-back ops from requester 0
        step();
        rst1 = 1'b0;
        step();
        chk("s1_idle", {27'd0, pulses1(), bs1.busy}, 32'd0);
        bs1.req0 = 1'b1; bs1.op0 = OP_ADD; bs1.a0 = pa[0]; bs1.b0 = pb[0];
        for (int c = 1; c <= 8; c++) begin
            int t;
            step();
            t = (c - 1) / 2;
            if ((c % 2) == 1) begin
                chk($sformatf("s1_gnt_c%0d", c), {28'd0, pulses1()}, 32'b1000);
                chk($sformatf("s1_alu_a_c%0d", c), bs1.alu_a, pa[t]);
                chk($sformatf("s1_alu_b_c%0d", c), bs1.alu_b, pb[t]);
                if (t < 3) begin
                    bs1.a0 = pa[t + 1];
                    bs1.b0 = pb[t + 1];
                end
            end else begin
                chk($sformatf("s1_done_c%0d", c), {28'd0, pulses1()}, 32'b0010);
                chk($sformatf("s1_result_c%0d", c), bs1.result, pr[t]);
                if (c == 8) bs1.req0 = 1'b0;
            end
        end
        step();
        chk("s1_final_idle", {27'd0, pulses1(), bs1.busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one structural ALU datapath (bitwise NOT/AND/OR, add, etc.) between two requesters.
- Arbitrates round-robin, latches the winner's opcode and operands, and holds them stable on the ALU inputs for a fixed settle time.
- Captures the ALU output, then returns it to the granted requester with a one-cycle done pulse.
- Sits between requesting control blocks and the combinational ALU top level.

Parameters:
- n, 32, operand/result width in bits
- OPW, 3, ALU opcode width in bits
- SETTLE, 2, clock cycles the ALU inputs are held before the result is captured; legal range 1..15

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 transaction request (level)
- op0  input  OPW  requester 0 opcode
- a0  input  n  requester 0 operand A
- b0  input  n  requester 0 operand B
- gnt0  output  1  one-cycle pulse: requester 0 operands accepted
- done0  output  1  one-cycle pulse: result valid for requester 0
- req1, op1, a1, b1, gnt1, done1: same as requester 0, for requester 1
- result  output  n  captured ALU result; valid while done0 or done1 is high, held otherwise
- alu_op  output  OPW  opcode driven to the ALU
- alu_a  output  n  operand A driven to the ALU
- alu_b  output  n  operand B driven to the ALU
- alu_out  input  n  combinational ALU result
- busy  output  1  high while a transaction is in EXEC

Behaviour:
- Reset, applied at any edge including mid-transaction:
  - state=IDLE; gnt0/1, done0/1, busy = 0; result, alu_op, alu_a, alu_b = 0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - An aborted transaction produces no done.
- States: IDLE, EXEC. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Only reqX high: winner=X.
  - Both high: winner is the requester not equal to last.
  - On a win, at that edge: alu_op/alu_a/alu_b <= opX/aX/bX; gntX <= 1; last <= X; cnt <= SETTLE; busy <= 1; state <= EXEC.
- EXEC:
  - Requests are ignored and alu_* are held constant.
  - Each edge decrements cnt. At the edge where cnt==1: result <= alu_out; doneX <= 1 for the latched winner; busy <= 0; state <= IDLE.
- Pulses: gnt and done are each high for exactly one cycle. gnt0 and gnt1 are never high together; the same holds for done0/done1. done never coincides with gnt of the same transaction.
- Latency, with the request sampled at edge k:
  - gnt is high in cycle k+1.
  - done is high in cycle k+SETTLE+1.
  - Next arbitration happens at edge k+SETTLE+1.
  - Throughput is one op per SETTLE+1 cycles.
- Requester protocol: deassert req in the cycle gnt is observed. A req still high at the next IDLE edge is treated as a new transaction; back-to-back issue from the same requester is legal.
- Fairness: a requester that is still requesting is never skipped twice in a row.
- Data widths: width is not changed; alu_out is captured unmodified.
- Opcode handling: opcodes pass through unchecked.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles, then req0=req1=0 for 10 cycles -> all outputs 0, busy=0 throughout.
- Single op, SETTLE=2: req0=1, op0=NOT, a0=32'h0000_FFFF at edge k -> gnt0 in cycle k+1; alu_a=32'h0000_FFFF held in cycles k+1..k+2; done0 in cycle k+3; result=32'hFFFF_0000; no activity on gnt1/done1.
- Simultaneous requests after reset: req0 and req1 both held high -> grant order 0,1,0,1. Each done goes to the matching requester with that requester's result. No cycle has two gnt or two done pulses.
- Request during EXEC: req1 rises one cycle after gnt0 -> req1 ignored until IDLE; gnt1 occurs at the edge after done0's setting edge. Requester 0's alu_* values are unchanged during its EXEC.
- Reset mid-operation: rst asserted in the first EXEC cycle -> no done0 ever appears for that op. The next simultaneous request is granted to requester 0 (last reset to 1).
- SETTLE=1 build: back-to-back req0 held high -> gnt0 every 2 cycles; done0 in each cycle between gnt0 pulses; result matches alu_out for each latched operand pair.
